fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Parametrised instruction-fetch stage that replaces the fixed pc_reg/ROM path of the openMIPS core.
- Generates sequential PCs and drives a ROM request/acknowledge handshake that tolerates wait states.
- Buffers returned instructions with their PCs in a prefetch FIFO, and presents them to the IF/ID boundary under an ID-side stall.
- Supports a branch redirect that flushes the buffer and discards in-flight responses.

Parameters:
ADDR_W, 32, PC and ROM address width
DATA_W, 32, instruction width
FIFO_DEPTH, 4, prefetch entries (power of two, >=2)
RESET_PC, 0, first fetch address after reset
PC_STEP, 4, byte increment per instruction

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-low reset
rom_ce_o  out  1  ROM enable, equals rom_req_o
rom_req_o  out  1  fetch request, held until acknowledged
rom_addr_o  out  ADDR_W  fetch address, stable while rom_req_o=1
rom_ack_i  in  1  ROM acknowledge, may be asserted in the same cycle as rom_req_o
rom_data_i  in  DATA_W  instruction, valid when rom_ack_i=1
redirect_i  in  1  branch/jump redirect pulse
redirect_pc_i  in  ADDR_W  redirect target; bits [1:0] ignored (forced 0)
stall_i  in  1  ID cannot accept; head entry held
id_valid_o  out  1  FIFO head valid
id_pc_o  out  ADDR_W  PC of head entry
id_inst_o  out  DATA_W  instruction of head entry

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, fetch_pc=RESET_PC, FIFO empty.
  - rom_req_o=0, rom_ce_o=0, rom_addr_o=0, id_valid_o=0, id_pc_o=0, id_inst_o=0.
- A reset asserted mid-request abandons the request. A later rom_ack_i is ignored because the block is then in IDLE.
- Outputs id_pc_o/id_inst_o are combinational from the FIFO head and are forced to 0 when the FIFO is empty.
- Pop: id_valid_o=1 and stall_i=0 at a rising edge.
- Credit: a new request may start only when occupancy + outstanding < FIFO_DEPTH, where outstanding = (state==REQ). A pop in the same cycle is not counted, so credit is conservative.
- State machine (registered):
  - IDLE: if credit and no redirect -> REQ, rom_addr_o=fetch_pc, rom_req_o=1.
  - REQ on rom_ack_i=1 without redirect:
    - push {rom_addr_o, rom_data_i}; fetch_pc += PC_STEP (modulo 2^ADDR_W; 0xFFFFFFFC wraps to 0).
    - If credit remains after the push -> stay REQ with the new address (back-to-back, 1 instruction/cycle with a zero-wait ROM); else -> IDLE.
  - REQ with rom_ack_i=0: hold rom_req_o and rom_addr_o unchanged.
  - REQ with redirect_i=1 and rom_ack_i=0 -> DROP. rom_req_o stays high with the old address; the request is never withdrawn.
  - REQ with redirect_i=1 and rom_ack_i=1: the data is discarded, not pushed -> IDLE.
  - DROP: wait for rom_ack_i, discard the data -> IDLE.
- Redirect (any state):
  - FIFO flushed at the edge; fetch_pc <= {redirect_pc_i[ADDR_W-1:2],2'b00}.
  - A pop in the same cycle is cancelled (flush wins).
  - Earliest request to the target: the cycle after the redirect (from IDLE) or after the DROP ack.
- Latency: an ack at edge t produces id_valid_o=1 in cycle t+1 if the FIFO was empty. There is no bypass.
- Full FIFO: no request issued. A push and a pop in the same cycle keep occupancy unchanged.
- redirect_i in DROP: fetch_pc is updated to the newest target, still wait for the ack.

Decomposition:
- Shared package (defines.v): fetch state encodings (IDLE/REQ/DROP), ZeroWord, fetch enable/disable constants, default RESET_PC.
- Sub-module fetch_fifo: synchronous FIFO of {pc,inst}.
  - Parameters: WIDTH, DEPTH.
  - Ports: push, pop, flush, count, full, empty, head data.
  - Pointer wrap uses a single extra bit.

Test Plan:
1. Reset release, zero-wait ROM (ack=req), stall_i=0 -> rom_addr_o 0,4,8,C on consecutive cycles; id_pc_o 0,4,8 from cycle 2 onward; id_valid_o continuous.
2. ROM with 2 wait states -> rom_addr_o held at 0x4 for 3 cycles with rom_req_o=1; no duplicate push; id_inst_o sequence matches ROM contents.
3. stall_i=1 for 10 cycles, DEPTH=4 -> exactly 4 entries buffered (PC 0..C), rom_req_o=0 afterwards; release -> PCs 0,4,8,C then 0x10 in order, no gap beyond 1 cycle.
4. redirect_i to 0x100 while a 3-wait-state request to 0x8 is pending -> request to 0x8 completes and is dropped; FIFO empty; next rom_addr_o=0x100; first id_pc_o=0x100.
5. redirect_i with redirect_pc_i=0x203 coincident with rom_ack_i and a pop -> nothing pushed, pop cancelled, next fetch address 0x200.
6. RESET_PC=0xFFFFFFF8 -> fetches 0xFFFFFFF8, 0xFFFFFFFC, 0x0; a mid-request rst=0 pulse returns all outputs to 0, then fetching restarts at 0xFFFFFFF8.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
// Shared definitions for the instruction-fetch stage:
//   - fetch_state_e  : fetch FSM encodings (IDLE / REQ / DROP)
//   - ZERO_WORD      : all-zero word used for idle outputs
//   - FETCH_ENABLE / FETCH_DISABLE : ROM enable levels
//   - DEFAULT_RESET_PC : default first fetch address after reset
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // no request outstanding
        ST_REQ  = 2'd1,   // request outstanding, response will be kept
        ST_DROP = 2'd2    // request outstanding, response will be discarded
    } fetch_state_e;

    localparam logic [31:0] ZERO_WORD        = 32'h0000_0000;
    localparam logic        FETCH_ENABLE     = 1'b1;
    localparam logic        FETCH_DISABLE    = 1'b0;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_fifo.sv
// -----------------------------------------------------------------------------
// fetch_unit_fifo
// Synchronous FIFO holding {pc, inst} prefetch entries.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   push_i         : write push_data_i (ignored when full or flushing)
//   pop_i          : retire head entry (ignored when empty or flushing)
//   flush_i        : empty the FIFO at the edge; wins over push and pop
//   push_data_i    : entry to write
//   head_data_o    : entry at the head (stale contents when empty)
//   count_o        : occupancy, 0..DEPTH
//   full_o/empty_o : occupancy flags
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// -----------------------------------------------------------------------------
module fetch_unit_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [WIDTH-1:0]         push_data_i,
    output logic [WIDTH-1:0]         head_data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    always_comb begin
        count_o  = wr_ptr_q - rd_ptr_q;
        empty_o  = (wr_ptr_q == rd_ptr_q);
        full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_push  = push_i && !full_o && !flush_i;
        do_pop   = pop_i && !empty_o && !flush_i;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only visible through the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end

    assign head_data_o = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage: generates sequential PCs, runs a ROM req/ack
// handshake tolerant of wait states, buffers {pc, inst} in a prefetch FIFO and
// presents the FIFO head to the IF/ID boundary.
// Ports:
//   clk, rst               : clock, asynchronous active-low reset
//   rom_ce_o / rom_req_o   : ROM enable / request (identical)
//   rom_addr_o             : fetch address
//   rom_ack_i, rom_data_i  : ROM acknowledge and instruction
//   redirect_i, redirect_pc_i : branch redirect pulse and target
//   stall_i                : ID cannot accept the head entry
//   id_valid_o, id_pc_o, id_inst_o : FIFO head towards ID (zero when empty)
//   dbg_state_o            : current fetch FSM state
// Handshakes:
//   ROM : rom_req_o rises with rom_addr_o valid and both hold until a cycle
//         with rom_ack_i=1 (possibly the first one); that edge completes the
//         transfer. A request is never withdrawn, even on redirect.
//   ID  : an entry transfers on a rising edge with id_valid_o=1, stall_i=0
//         and redirect_i=0.
// -----------------------------------------------------------------------------
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(DEFAULT_RESET_PC),
    parameter int                PC_STEP    = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic              rom_ce_o,
    output logic              rom_req_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic              rom_ack_i,
    input  logic [DATA_W-1:0] rom_data_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    input  logic              stall_i,
    output logic              id_valid_o,
    output logic [ADDR_W-1:0] id_pc_o,
    output logic [DATA_W-1:0] id_inst_o,
    output fetch_state_e      dbg_state_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e             state_q, state_d;
    logic [ADDR_W-1:0]        fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]        addr_q, addr_d;
    logic                     req_q, req_d;

    logic [CW-1:0]            fifo_count;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     fifo_push;
    logic                     fifo_pop;
    logic [ADDR_W+DATA_W-1:0] fifo_head;

    logic                     credit_idle;
    logic                     credit_after_push;
    logic [ADDR_W-1:0]        next_pc;
    logic [ADDR_W-1:0]        redirect_pc;
    logic                     unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

    always_comb begin
        // Credit counts only entries already held; a pop in the same cycle
        // is ignored so the FIFO can never be overrun.
        credit_idle       = 32'(fifo_count) < 32'(FIFO_DEPTH);
        credit_after_push = (32'(fifo_count) + 32'd1) < 32'(FIFO_DEPTH);
        next_pc           = fetch_pc_q + ADDR_W'(PC_STEP);
        redirect_pc       = {redirect_pc_i[ADDR_W-1:2], 2'b00};

        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        req_d      = req_q;
        fifo_push  = 1'b0;
        fifo_pop   = !fifo_empty && !stall_i && !redirect_i;

        case (state_q)
            ST_IDLE: begin
                if (!redirect_i && credit_idle) begin
                    state_d = ST_REQ;
                    addr_d  = fetch_pc_q;
                    req_d   = FETCH_ENABLE;
                end
            end
            ST_REQ: begin
                if (redirect_i) begin
                    if (rom_ack_i) begin
                        state_d = ST_IDLE;
                        req_d   = FETCH_DISABLE;
                    end else begin
                        // Request stays on the bus; its response is dropped.
                        state_d = ST_DROP;
                    end
                end else if (rom_ack_i) begin
                    fifo_push  = 1'b1;
                    fetch_pc_d = next_pc;
                    if (credit_after_push) begin
                        addr_d = next_pc;
                    end else begin
                        state_d = ST_IDLE;
                        req_d   = FETCH_DISABLE;
                    end
                end
            end
            ST_DROP: begin
                if (rom_ack_i) begin
                    state_d = ST_IDLE;
                    req_d   = FETCH_DISABLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = FETCH_DISABLE;
            end
        endcase

        if (redirect_i) fetch_pc_d = redirect_pc;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= ADDR_W'(ZERO_WORD);
            req_q      <= FETCH_DISABLE;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
        end
    end

    fetch_unit_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst),
        .push_i      (fifo_push),
        .pop_i       (fifo_pop),
        .flush_i     (redirect_i),
        .push_data_i ({addr_q, rom_data_i}),
        .head_data_o (fifo_head),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    logic unused_fifo_full;
    assign unused_fifo_full = fifo_full;

    assign rom_req_o   = req_q;
    assign rom_ce_o    = req_q;
    assign rom_addr_o  = addr_q;
    assign id_valid_o  = !fifo_empty;
    assign id_pc_o     = fifo_empty ? ADDR_W'(ZERO_WORD)
                                    : fifo_head[ADDR_W+DATA_W-1:DATA_W];
    assign id_inst_o   = fifo_empty ? DATA_W'(ZERO_WORD)
                                    : fifo_head[DATA_W-1:0];
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Two fetch_unit instances (RESET_PC 0 and 0xFFFFFFF8) share all inputs; the
// bench observes the one selected by 'sel'. A ROM responder with a
// configurable wait-state count answers requests; every kept response pushes
// its expected {pc, inst} into exp_q, and the ID side is compared against the
// queue head every cycle.
// -----------------------------------------------------------------------------
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic        stall_i       = 1'b0;
    logic        redirect_i    = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic        rom_ack_i     = 1'b0;
    logic [31:0] rom_data_i    = 32'h0;
    logic        sel           = 1'b0;

    logic         ce0, req0, val0, ce1, req1, val1;
    logic [31:0]  addr0, pc0, inst0, addr1, pc1, inst1;
    fetch_state_e st0, st1;

    logic         ce, req, valid;
    logic [31:0]  addr, pc, inst;
    fetch_state_e st;

    assign ce    = sel ? ce1   : ce0;
    assign req   = sel ? req1  : req0;
    assign valid = sel ? val1  : val0;
    assign addr  = sel ? addr1 : addr0;
    assign pc    = sel ? pc1   : pc0;
    assign inst  = sel ? inst1 : inst0;
    assign st    = sel ? st1   : st0;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut0 (
        .clk(clk), .rst(rst), .rom_ce_o(ce0), .rom_req_o(req0), .rom_addr_o(addr0),
        .rom_ack_i(rom_ack_i), .rom_data_i(rom_data_i), .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i), .stall_i(stall_i), .id_valid_o(val0),
        .id_pc_o(pc0), .id_inst_o(inst0), .dbg_state_o(st0)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut1 (
        .clk(clk), .rst(rst), .rom_ce_o(ce1), .rom_req_o(req1), .rom_addr_o(addr1),
        .rom_ack_i(rom_ack_i), .rom_data_i(rom_data_i), .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i), .stall_i(stall_i), .id_valid_o(val1),
        .id_pc_o(pc1), .id_inst_o(inst1), .dbg_state_o(st1)
    );

    // ---------------- scoreboard state ----------------
    logic [63:0] exp_q[$];
    logic [31:0] exp_pc;
    logic        dropping;
    int          waits;
    int          wait_cnt;
    int          n_cmp = 0;
    int          n_err = 0;

    function automatic logic [31:0] rom_f(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset(input logic which);
        @(negedge clk);
        rst        = 1'b0;
        sel        = which;
        stall_i    = 1'b0;
        redirect_i = 1'b0;
        rom_ack_i  = 1'b0;
        wait_cnt   = 0;
        dropping   = 1'b0;
        exp_q.delete();
        exp_pc     = which ? 32'hFFFF_FFF8 : 32'h0;
        #1;
        check_eq("rst_req",   64'(req),   64'd0);
        check_eq("rst_ce",    64'(ce),    64'd0);
        check_eq("rst_addr",  64'(addr),  64'd0);
        check_eq("rst_valid", 64'(valid), 64'd0);
        check_eq("rst_id",    {pc, inst}, 64'd0);
        check_eq("rst_state", 64'(st),    64'(ST_IDLE));
        @(negedge clk);
        rst = 1'b1;
    endtask

    // One clock cycle: drive inputs at the falling edge, let the ROM respond,
    // update the model for the coming rising edge, return just after it.
    task automatic step(input logic redir, input logic [31:0] tgt, input logic stl);
        @(negedge clk);
        redirect_i    = redir;
        redirect_pc_i = tgt;
        stall_i       = stl;
        if (req) begin
            if (wait_cnt >= waits) begin
                rom_ack_i  = 1'b1;
                rom_data_i = rom_f(addr);
                wait_cnt   = 0;
            end else begin
                rom_ack_i  = 1'b0;
                rom_data_i = 32'hx;
                wait_cnt++;
            end
        end else begin
            rom_ack_i = 1'b0;
            wait_cnt  = 0;
        end
        #1;
        check_eq("id_valid", 64'(valid), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            check_eq("id_head", {pc, inst}, exp_q[0]);
            if (!stl && !redir) void'(exp_q.pop_front());
        end
        if (rom_ack_i) begin
            if (!dropping && !redir) begin
                check_eq("rom_addr", 64'(addr), 64'(exp_pc));
                exp_q.push_back({exp_pc, rom_f(exp_pc)});
                exp_pc = exp_pc + 32'd4;
            end
            dropping = 1'b0;
        end else if (req && redir) begin
            dropping = 1'b1;
        end
        if (redir) begin
            exp_q.delete();
            exp_pc = tgt & ~32'h3;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, input logic stl);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, stl);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int  n4;
        logic found;

        // 1: zero-wait streaming from reset
        waits = 0;
        do_reset(1'b0);
        run(12, 1'b0);
        check_eq("t1_stream_valid", 64'(valid), 64'd1);

        // 2: two wait states, address held three cycles
        do_reset(1'b0);
        waits = 2;
        n4 = 0;
        for (int i = 0; i < 20; i++) begin
            if (req && addr == 32'h4) n4++;
            step(1'b0, 32'h0, 1'b0);
        end
        check_eq("t2_addr4_cycles", 64'(n4), 64'd3);

        // 3: stall fills the FIFO, no further requests, then drains in order
        do_reset(1'b0);
        waits = 0;
        run(10, 1'b1);
        check_eq("t3_buffered", 64'(exp_q.size()), 64'd4);
        check_eq("t3_req_off",  64'(req), 64'd0);
        check_eq("t3_state",    64'(st),  64'(ST_IDLE));
        run(10, 1'b0);

        // 4: redirect while a 3-wait request to 0x8 is pending
        do_reset(1'b0);
        waits = 3;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (req && addr == 32'h8) found = 1'b1;
            else step(1'b0, 32'h0, 1'b0);
        end
        check_eq("t4_reach_8", 64'(found), 64'd1);
        step(1'b1, 32'h0000_0100, 1'b0);
        check_eq("t4_drop_state", 64'(st),   64'(ST_DROP));
        check_eq("t4_drop_hold",  {31'd0, req, addr}, {31'd0, 1'b1, 32'h8});
        check_eq("t4_flushed",    64'(valid), 64'd0);
        run(20, 1'b0);

        // 5: redirect coincident with ack and pop
        do_reset(1'b0);
        waits = 0;
        run(6, 1'b0);
        check_eq("t5_busy", 64'({req, valid}), 64'(2'b11));
        step(1'b1, 32'h0000_0203, 1'b0);
        check_eq("t5_flushed", 64'(valid), 64'd0);
        check_eq("t5_state",   64'(st),    64'(ST_IDLE));
        step(1'b0, 32'h0, 1'b0);
        check_eq("t5_next_addr", {31'd0, req, addr}, {31'd0, 1'b1, 32'h200});
        run(8, 1'b0);

        // 6: wrap-around reset PC, mid-request reset, ignored late ack
        do_reset(1'b1);
        waits = 0;
        run(6, 1'b0);
        waits = 3;
        run(2, 1'b0);
        check_eq("t6_pending", 64'(req), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check_eq("t6_rst_req",   64'({ce, req}), 64'd0);
        check_eq("t6_rst_addr",  64'(addr),      64'd0);
        check_eq("t6_rst_id",    {pc, inst},     64'd0);
        check_eq("t6_rst_valid", 64'(valid),     64'd0);
        exp_q.delete();
        exp_pc   = 32'hFFFF_FFF8;
        dropping = 1'b0;
        wait_cnt = 0;
        waits    = 0;
        @(negedge clk);
        rom_ack_i  = 1'b0;
        @(negedge clk);
        rst        = 1'b1;
        rom_ack_i  = 1'b1;           // late ack arriving while IDLE
        rom_data_i = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        check_eq("t6_restart", {30'd0, st, addr}, {30'd0, ST_REQ, 32'hFFFF_FFF8});
        run(8, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
